// File: rtl/tinyqv_mem_arbiter.sv
// tinyqv_mem_arbiter: shares the QSPI memory-controller port between the
// continuous instruction-fetch stream and core load/store transactions.
// Fetch runs as an open-ended halfword stream; a data request, stall or
// restart stops it, data is served, then fetch resumes at the first
// halfword that was not delivered.
//
// Optional feature macro: TINYQV_ARB_FETCH_MIN_EN
//   When defined, data_req may only pre-empt a fetch stream after it has
//   delivered FETCH_MIN_BEATS beats (stall/restart still stop at once).
//
// Handshake: data_req is held by the core until data_ack; data_ack is a
// one-cycle pulse and the core drops data_req in the following cycle.
// The controller sees one mem_start pulse per transaction, raises mem_busy
// from the next cycle until idle, and honours mem_stop for fetch streams.
module tinyqv_mem_arbiter #(
    parameter int ADDR_BITS       = 24,
    parameter int FETCH_MIN_BEATS = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 instr_start,
    input  logic [ADDR_BITS-1:0] instr_addr,
    input  logic                 instr_stall,
    output logic [15:0]          instr_data,
    output logic                 instr_valid,
    input  logic                 data_req,
    input  logic                 data_write,
    input  logic [1:0]           data_size,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [31:0]          data_wdata,
    output logic [31:0]          data_rdata,
    output logic                 data_ack,
    output logic                 mem_start,
    output logic                 mem_stop,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_write,
    output logic [1:0]           mem_size,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_busy,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_rvalid,
    input  logic                 mem_done
);

    typedef enum logic [1:0] {IDLE, FETCH, STOP, DATA} state_t;

    state_t                 state, state_d;
    logic                   fetch_pending, fetch_pending_d;
    logic [ADDR_BITS-1:0]   fetch_addr, fetch_addr_d;
    logic                   rd_beat, rd_beat_d;
    logic [31:0]            rd_buf, rd_buf_d;
    logic                   mem_start_d, mem_stop_d, mem_write_d, data_ack_d;
    logic [ADDR_BITS-1:0]   mem_addr_d;
    logic [1:0]             mem_size_d;
    logic [31:0]            mem_wdata_d, data_rdata_d;
    logic                   data_preempt;
    logic                   can_start;

    // Bit 0 of the restart address is dropped (halfword aligned fetch).
    logic unused_cfg;
    assign unused_cfg = instr_addr[0] ^ (FETCH_MIN_BEATS > 0);

    // Fetch beats go straight to the consumer; a same-cycle restart kills the beat.
    assign instr_valid = (state == FETCH) && mem_rvalid && !instr_start;
    assign instr_data  = mem_rdata;

    // A new transaction never starts while the controller is busy or in the ack cycle.
    assign can_start = !mem_busy && !data_ack;

`ifdef TINYQV_ARB_FETCH_MIN_EN
    localparam int CNT_W = $clog2(FETCH_MIN_BEATS + 2);
    logic [CNT_W-1:0] beat_cnt, beat_cnt_d;

    // Count delivered beats in the current stream, saturating at the minimum.
    always_comb begin
        beat_cnt_d = beat_cnt;
        if (state != FETCH)
            beat_cnt_d = '0;
        else if (mem_rvalid && (beat_cnt < CNT_W'(FETCH_MIN_BEATS)))
            beat_cnt_d = beat_cnt + CNT_W'(1);
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) beat_cnt <= '0;
        else       beat_cnt <= beat_cnt_d;
    end

    assign data_preempt = data_req && (beat_cnt >= CNT_W'(FETCH_MIN_BEATS));
`else
    assign data_preempt = data_req;
`endif

    // Next-state and next registered-output logic.
    always_comb begin
        state_d         = state;
        fetch_pending_d = fetch_pending;
        fetch_addr_d    = fetch_addr;
        rd_beat_d       = rd_beat;
        rd_buf_d        = rd_buf;
        mem_start_d     = 1'b0;
        mem_stop_d      = mem_stop;
        mem_addr_d      = mem_addr;
        mem_write_d     = mem_write;
        mem_size_d      = mem_size;
        mem_wdata_d     = mem_wdata;
        data_ack_d      = 1'b0;
        data_rdata_d    = data_rdata;
        case (state)
            IDLE: begin
                if (can_start) begin
                    if (data_req) begin
                        mem_start_d = 1'b1;
                        mem_addr_d  = data_addr;
                        mem_write_d = data_write;
                        mem_size_d  = data_size;
                        mem_wdata_d = data_wdata;
                        rd_buf_d    = '0;
                        rd_beat_d   = 1'b0;
                        state_d     = DATA;
                    end else if (fetch_pending && !instr_stall && !instr_start) begin
                        // Fetch streams carry no store data.
                        mem_start_d = 1'b1;
                        mem_addr_d  = fetch_addr;
                        mem_write_d = 1'b0;
                        mem_size_d  = 2'd3;
                        mem_wdata_d = '0;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                // The beat of the stop cycle is still delivered, so it advances too.
                if (mem_rvalid)
                    fetch_addr_d = fetch_addr + ADDR_BITS'(2);
                if (data_preempt || instr_stall || instr_start) begin
                    mem_stop_d = 1'b1;
                    state_d    = STOP;
                end
            end
            STOP: begin
                // Late beats are dropped; resume point is already fetch_addr.
                if (!mem_busy) begin
                    mem_stop_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            DATA: begin
                if (mem_rvalid && !mem_write) begin
                    if (!rd_beat) rd_buf_d[15:0]  = mem_rdata;
                    else          rd_buf_d[31:16] = mem_rdata;
                    rd_beat_d = 1'b1;
                end
                if (mem_done) begin
                    data_ack_d = 1'b1;
                    state_d    = IDLE;
                    // Publish only on completion so the previous result stays stable.
                    if (!mem_write) begin
                        case (mem_size)
                            2'd0:    data_rdata_d = {24'd0, rd_buf_d[7:0]};
                            2'd1:    data_rdata_d = {16'd0, rd_buf_d[15:0]};
                            default: data_rdata_d = rd_buf_d;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A restart wins over any same-cycle increment, in every state.
        if (instr_start) begin
            fetch_addr_d    = {instr_addr[ADDR_BITS-1:1], 1'b0};
            fetch_pending_d = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            fetch_pending <= 1'b0;
            fetch_addr    <= '0;
            rd_beat       <= 1'b0;
            rd_buf        <= '0;
            mem_start     <= 1'b0;
            mem_stop      <= 1'b0;
            mem_addr      <= '0;
            mem_write     <= 1'b0;
            mem_size      <= 2'd0;
            mem_wdata     <= '0;
            data_ack      <= 1'b0;
            data_rdata    <= '0;
        end else begin
            state         <= state_d;
            fetch_pending <= fetch_pending_d;
            fetch_addr    <= fetch_addr_d;
            rd_beat       <= rd_beat_d;
            rd_buf        <= rd_buf_d;
            mem_start     <= mem_start_d;
            mem_stop      <= mem_stop_d;
            mem_addr      <= mem_addr_d;
            mem_write     <= mem_write_d;
            mem_size      <= mem_size_d;
            mem_wdata     <= mem_wdata_d;
            data_ack      <= data_ack_d;
            data_rdata    <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Testbench for tinyqv_mem_arbiter: directed stimulus, expected events are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_tinyqv_mem_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          instr_start = 1'b0;
    logic [AW-1:0] instr_addr = '0;
    logic          instr_stall = 1'b0;
    logic [15:0]   instr_data;
    logic          instr_valid;
    logic          data_req = 1'b0;
    logic          data_write = 1'b0;
    logic [1:0]    data_size = 2'd0;
    logic [AW-1:0] data_addr = '0;
    logic [31:0]   data_wdata = '0;
    logic [31:0]   data_rdata;
    logic          data_ack;
    logic          mem_start;
    logic          mem_stop;
    logic [AW-1:0] mem_addr;
    logic          mem_write;
    logic [1:0]    mem_size;
    logic [31:0]   mem_wdata;
    logic          mem_busy = 1'b0;
    logic [15:0]   mem_rdata = '0;
    logic          mem_rvalid = 1'b0;
    logic          mem_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    tinyqv_mem_arbiter #(.ADDR_BITS(AW), .FETCH_MIN_BEATS(2)) dut (
        .clk(clk), .rstn(rstn),
        .instr_start(instr_start), .instr_addr(instr_addr), .instr_stall(instr_stall),
        .instr_data(instr_data), .instr_valid(instr_valid),
        .data_req(data_req), .data_write(data_write), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack),
        .mem_start(mem_start), .mem_stop(mem_stop), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_done(mem_done)
    );

    // Clock.
    always #5 clk = ~clk;

    // Event encodings: [63:62] kind (1 instr beat, 2 data ack, 3 mem_start).
    function automatic logic [63:0] enc_start(input logic w, input logic [1:0] sz,
                                              input logic [AW-1:0] a, input logic [31:0] wd);
        return {2'd3, 3'd0, w, sz, a, (w ? wd : 32'd0)};
    endfunction
    function automatic logic [63:0] enc_beat(input logic [15:0] d);
        return {2'd1, 46'd0, d};
    endfunction
    function automatic logic [63:0] enc_ack(input logic [31:0] d);
        return {2'd2, 30'd0, d};
    endfunction

    task automatic sb_check(input logic [63:0] obs, input string name);
        logic [63:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event got=%h required=none", name, obs);
        end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s: got=%h required=%h", name, obs, exp);
            end
        end
    endtask

    // Monitor: every DUT output event is matched against the expected queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (mem_start)
                sb_check({2'd3, 3'd0, mem_write, mem_size, mem_addr,
                          (mem_write ? mem_wdata : 32'd0)}, "mem_start");
            if (instr_valid) sb_check(enc_beat(instr_data), "instr_beat");
            if (data_ack)    sb_check(enc_ack(data_rdata), "data_ack");
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until the DUT presents mem_start in the current cycle.
    task automatic wait_start(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (mem_start) seen = 1'b1;
            else tick();
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: mem_start got=none required=pulse within 40 cycles", name);
        end
    endtask

    // One controller read beat; expect_instr queues the matching fetch delivery.
    task automatic beat(input logic [15:0] d, input bit expect_instr);
        if (expect_instr) exp_q.push_back(enc_beat(d));
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic set_data(input logic w, input logic [1:0] sz,
                            input logic [AW-1:0] a, input logic [31:0] wd);
        data_req   = 1'b1;
        data_write = w;
        data_size  = sz;
        data_addr  = a;
        data_wdata = wd;
    endtask

    // Completes a data transaction and the core's one-cycle-late drop of data_req.
    task automatic finish_data(input logic [31:0] ack_val);
        exp_q.push_back(enc_ack(ack_val));
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        mem_busy = 1'b0;
        tick();
        data_req   = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin
        int starts;
        bit stop_seen;
        // Reset values.
        #12;
        chk("rst_mem_start", {31'd0, mem_start}, 32'd0);
        chk("rst_mem_stop", {31'd0, mem_stop}, 32'd0);
        chk("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
        chk("rst_mem_size_write", {29'd0, mem_write, mem_size}, 32'd0);
        chk("rst_data", {30'd0, data_ack, instr_valid}, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        tick();

        // Fetch from 0x000100, four beats.
        instr_start = 1'b1;
        instr_addr  = 24'h000100;
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h000100, 32'd0));
        tick();
        instr_start = 1'b0;
        wait_start("fetch_0100");
        tick();
        mem_busy = 1'b1;
        beat(16'h1111, 1'b1);
        beat(16'h2222, 1'b1);
        beat(16'h3333, 1'b1);
        beat(16'h4444, 1'b1);

        // Stall, then release: resume at 0x000108.
        instr_stall = 1'b1;
        tick();
        chk("stall_stop_high", {31'd0, mem_stop}, 32'd1);
        mem_busy = 1'b0;
        tick();
        chk("stall_stop_low", {31'd0, mem_stop}, 32'd0);
        tick();
        tick();
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h000108, 32'd0));
        instr_stall = 1'b0;
        wait_start("fetch_0108");
        tick();
        mem_busy = 1'b1;
        beat(16'h5555, 1'b1);
        beat(16'h6666, 1'b1);

        // Load word pre-empts fetch; a beat during STOP is dropped.
        set_data(1'b0, 2'd2, 24'h001000, 32'd0);
        tick();
        chk("load_stop_high", {31'd0, mem_stop}, 32'd1);
        beat(16'h7777, 1'b0);
        mem_busy = 1'b0;
        exp_q.push_back(enc_start(1'b0, 2'd2, 24'h001000, 32'd0));
        wait_start("load_word");
        tick();
        mem_busy = 1'b1;
        beat(16'hBEEF, 1'b0);
        beat(16'hDEAD, 1'b0);
        finish_data(32'hDEADBEEF);
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h00010C, 32'd0));
        wait_start("fetch_010C");

        // Stop fetch, then a store byte while idle; read data must stay held.
        tick();
        mem_busy    = 1'b1;
        instr_stall = 1'b1;
        tick();
        mem_busy = 1'b0;
        tick();
        set_data(1'b1, 2'd0, 24'h000023, 32'h0000005A);
        exp_q.push_back(enc_start(1'b1, 2'd0, 24'h000023, 32'h0000005A));
        wait_start("store_byte");
        tick();
        mem_busy = 1'b1;
        beat(16'hFFFF, 1'b0);
        finish_data(32'hDEADBEEF);
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h00010C, 32'd0));
        instr_stall = 1'b0;
        wait_start("fetch_010C_again");

        // Load half: one beat, upper half zero.
        tick();
        mem_busy = 1'b1;
        set_data(1'b0, 2'd1, 24'h002000, 32'd0);
        tick();
        mem_busy = 1'b0;
        exp_q.push_back(enc_start(1'b0, 2'd1, 24'h002000, 32'd0));
        wait_start("load_half");
        tick();
        mem_busy = 1'b1;
        beat(16'h8001, 1'b0);
        finish_data(32'h00008001);
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h00010C, 32'd0));
        wait_start("fetch_after_half");

        // Restart to 0xFFFFFF (bit 0 dropped) with a same-cycle beat that must not deliver.
        tick();
        mem_busy    = 1'b1;
        instr_start = 1'b1;
        instr_addr  = 24'hFFFFFF;
        mem_rvalid  = 1'b1;
        mem_rdata   = 16'h9999;
        tick();
        instr_start = 1'b0;
        mem_rvalid  = 1'b0;
        mem_busy    = 1'b0;
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'hFFFFFE, 32'd0));
        wait_start("fetch_FFFFFE");
        tick();
        mem_busy = 1'b1;
        beat(16'hAAAA, 1'b1);
        beat(16'hBBBB, 1'b1);
        instr_stall = 1'b1;
        tick();
        mem_busy = 1'b0;
        tick();
        tick();
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h000002, 32'd0));
        instr_stall = 1'b0;
        wait_start("fetch_wrap_0002");

        // Data request raised in the fetch mem_start cycle.
        set_data(1'b0, 2'd2, 24'h003000, 32'd0);
`ifdef TINYQV_ARB_FETCH_MIN_EN
        tick();
        mem_busy = 1'b1;
        chk("min_no_stop_0", {31'd0, mem_stop}, 32'd0);
        beat(16'hC001, 1'b1);
        chk("min_no_stop_1", {31'd0, mem_stop}, 32'd0);
        beat(16'hC002, 1'b1);
        stop_seen = 1'b0;
        for (int i = 0; i < 4 && !stop_seen; i++) begin
            if (mem_stop) stop_seen = 1'b1;
            else tick();
        end
        chk("min_stop_after_2", {31'd0, stop_seen}, 32'd1);
`else
        tick();
        chk("preempt_first_cycle", {31'd0, mem_stop}, 32'd1);
`endif
        mem_busy = 1'b0;
        exp_q.push_back(enc_start(1'b0, 2'd2, 24'h003000, 32'd0));
        wait_start("load_3000");
        tick();
        mem_busy = 1'b1;
        beat(16'h0001, 1'b0);
        beat(16'h0002, 1'b0);
        finish_data(32'h00020001);
`ifdef TINYQV_ARB_FETCH_MIN_EN
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h000006, 32'd0));
`else
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h000002, 32'd0));
`endif
        wait_start("fetch_after_3000");

        // Async reset in the middle of a data transaction.
        tick();
        mem_busy = 1'b1;
        set_data(1'b0, 2'd2, 24'h004000, 32'd0);
        tick();
        mem_busy = 1'b0;
        exp_q.push_back(enc_start(1'b0, 2'd2, 24'h004000, 32'd0));
        wait_start("load_4000");
        tick();
        mem_busy = 1'b1;
        beat(16'h1234, 1'b0);
        #2;
        rstn       = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("arst_mem_start_stop", {30'd0, mem_start, mem_stop}, 32'd0);
        chk("arst_mem_addr", {8'd0, mem_addr}, 32'd0);
        chk("arst_size_write", {29'd0, mem_write, mem_size}, 32'd0);
        chk("arst_data_rdata", data_rdata, 32'd0);
        chk("arst_ack_valid", {30'd0, data_ack, instr_valid}, 32'd0);
        mem_rvalid = 1'b0;
        mem_busy   = 1'b0;
        data_req   = 1'b0;
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_start) starts++;
        end
        chk("no_start_after_reset", starts, 32'd0);
        instr_start = 1'b1;
        instr_addr  = 24'h000500;
        exp_q.push_back(enc_start(1'b0, 2'd3, 24'h000500, 32'd0));
        tick();
        instr_start = 1'b0;
        wait_start("fetch_after_reset");
        tick();
        tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
